fifo_rr_ctrl: RTL and testbench
===============================

# fifo_rr_ctrl

Controller that sequences a `rkob_ptp_ram` instance as a circular FIFO shared by two write requesters and one reader. It owns the write/read pointers, the occupancy count and the full/empty flags, and arbitrates the single RAM write port between requesters 0 and 1 in round-robin order. It sits between producer logic and the dual-port RAM and drives all RAM address, data and enable inputs; the RAM `rd_data` output goes directly to the consumer.

## Interface
- `DATA_WIDTH`, 12: width of write data and RAM word.
- `ADDR_WIDTH`, 12: RAM address width.
- `STACK_DEPTH`, 12'd5: number of RAM entries used, legal range 2..2^ADDR_WIDTH; addresses 0..STACK_DEPTH-1.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `kill`  in  1  reset, synchronous, active-high.
- `wr0_req`  in  1  requester 0 write request; held until acknowledged.
- `wr0_data`  in  DATA_WIDTH  requester 0 write data.
- `wr0_ack`  out  1  combinational; requester 0 write accepted this cycle.
- `wr1_req`  in  1  requester 1 write request.
- `wr1_data`  in  DATA_WIDTH  requester 1 write data.
- `wr1_ack`  out  1  combinational; requester 1 write accepted this cycle.
- `rd_req`  in  1  read request.
- `rd_ack`  out  1  combinational; read accepted this cycle.
- `rd_valid`  out  1  registered; RAM `rd_data` holds the popped word this cycle.
- `ram_we`  out  1  to RAM `we`.
- `ram_wr_addr`  out  ADDR_WIDTH  to RAM `wr_addr`.
- `ram_wr_data`  out  DATA_WIDTH  to RAM `wr_data`.
- `ram_rd_addr`  out  ADDR_WIDTH  to RAM `rd_addr`.
- `count`  out  ADDR_WIDTH+1  registered occupancy, 0..STACK_DEPTH.
- `full`  out  1  registered, `count == STACK_DEPTH`.
- `empty`  out  1  registered, `count == 0`.

## Operation
- State: `wr_ptr`, `rd_ptr` (ADDR_WIDTH), `count`, `rr_ptr` (1 bit, the favoured requester), `rd_valid`.
- Write grant (combinational), only when `!kill && !full`:
  - one requester active: grant it;
  - both active: grant `rr_ptr`;
  - on any grant to requester i, `rr_ptr <= !i` next edge; no grant leaves `rr_ptr` unchanged.
- `ram_we = wr0_ack | wr1_ack`. `ram_wr_addr = wr_ptr`. `ram_wr_data` is the granted requester's data; when there is no grant it is `wr0_data`.
- Read accept: `rd_ack = rd_req && !empty && !kill`. `ram_rd_addr = rd_ptr` at all times.
- Pointer wrap: a pointer equal to STACK_DEPTH-1 advances to 0; otherwise it advances by 1. Write accept advances `wr_ptr`; read accept advances `rd_ptr`.
- Count: write only gives +1; read only gives −1; both or neither leaves it unchanged. `full` and `empty` are registered from the next-state count.
- No fall-through:
  - when `empty`, a read is refused even if a write is accepted in the same cycle;
  - when `full`, writes are refused even if a read is accepted in the same cycle.
- Refused requests are not lost; the requester keeps `req` high.
- Write data is consumed only on the ack cycle.

## Timing
- Reset: `kill` high at an edge sets:
  - `wr_ptr`, `rd_ptr`, `count` and `rr_ptr` to 0;
  - `rd_valid` to 0, `empty` to 1, `full` to 0.
- While `kill` is high, all acks and `ram_we` are 0.
- A `kill` mid-operation discards the contents. RAM contents are not cleared but become unreachable.
- Write: ack is in cycle N, the RAM is written at the edge ending N, and `count`/`full`/`empty` update in N+1.
- Read: ack is in cycle N, the RAM registers `mem[rd_ptr]` at the edge ending N, and `rd_valid`=1 with valid data in N+1. `rd_valid` is high for exactly one cycle per accepted read.
- Back-to-back reads every cycle give back-to-back `rd_valid`.
- Read/write address collision is impossible: read requires `count>0`, so the entry was written at an earlier edge.
- Throughput: one write and one read per cycle.

## Test plan
- Reset/idle:
  - assert `kill` for 2 cycles then release;
  - no requests → `count`=0, `empty`=1, `full`=0, `rd_valid`=0, `ram_we`=0.
- Single requester fill/drain (STACK_DEPTH=5):
  - `wr0` writes 10,20,30,40,50 → `full`=1 after the 5th ack, and a 6th request is not acked;
  - 5 reads → `rd_valid` data 10..50 in order, then `empty`=1.
- Round-robin:
  - both requests held high with data 0xA00+k / 0xB00+k;
  - acks alternate wr0,wr1,wr0,wr1,wr0; FIFO stays full while reads are off;
  - drained order is A00,B00,A01,B01,A02.
- Wrap-around:
  - run 13 writes and 13 reads interleaved with `count` ≤3;
  - `ram_wr_addr` sequence is 0,1,2,3,4,0,1,…; read data matches write order;
  - `count` is unchanged on simultaneous accept cycles.
- Boundaries:
  - at `full`, with `rd_req` and `wr0_req` together → only `rd_ack`, then `count`=4;
  - at `empty`, with `rd_req` and `wr1_req` together → only `wr1_ack`, and `rd_valid` stays 0 next cycle.
- Kill mid-stream:
  - with `count`=3 and a read acked in cycle N, assert `kill` in N+1;
  - → `rd_valid`=1 in N+1 only; after the kill edge: `count`=0, `empty`=1, pointers 0, and the next write goes to address 0.

Source files
------------

// File: rtl/fifo_rr_ctrl.sv
// fifo_rr_ctrl
//   Circular-FIFO sequencer for a dual-port RAM with a registered read port.
//   Two write requesters share the single RAM write port in round-robin order.
//   One reader pops entries. The popped word appears on the RAM read data
//   one cycle after rd_ack, and rd_valid marks that cycle.
//
// Ports
//   clk, kill                 clock, synchronous active-high reset
//   wrN_req/wrN_data/wrN_ack  write requesters 0 and 1 (acks combinational)
//   rd_req/rd_ack             read request and accept (ack combinational)
//   rd_valid                  RAM read data holds the popped word this cycle
//   ram_we/ram_wr_addr/ram_wr_data/ram_rd_addr   RAM control
//   count/full/empty          registered occupancy and flags
module fifo_rr_ctrl #(
    parameter int unsigned DATA_WIDTH  = 12,
    parameter int unsigned ADDR_WIDTH  = 12,
    parameter int unsigned STACK_DEPTH = 5
) (
    input  logic                  clk,
    input  logic                  kill,
    input  logic                  wr0_req,
    input  logic [DATA_WIDTH-1:0] wr0_data,
    output logic                  wr0_ack,
    input  logic                  wr1_req,
    input  logic [DATA_WIDTH-1:0] wr1_data,
    output logic                  wr1_ack,
    input  logic                  rd_req,
    output logic                  rd_ack,
    output logic                  rd_valid,
    output logic                  ram_we,
    output logic [ADDR_WIDTH-1:0] ram_wr_addr,
    output logic [DATA_WIDTH-1:0] ram_wr_data,
    output logic [ADDR_WIDTH-1:0] ram_rd_addr,
    output logic [ADDR_WIDTH:0]   count,
    output logic                  full,
    output logic                  empty
);

    localparam logic [ADDR_WIDTH-1:0] LAST_C  = ADDR_WIDTH'(STACK_DEPTH - 1);
    localparam logic [ADDR_WIDTH:0]   DEPTH_C = (ADDR_WIDTH + 1)'(STACK_DEPTH);

    logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_WIDTH:0]   count_q, count_d;
    logic                  rr_q, rr_d;
    logic                  rd_valid_q;
    logic                  full_q, empty_q;

    logic                  wr_ok, gnt0, gnt1, wr_acc, rd_acc;

    function automatic logic [ADDR_WIDTH-1:0] ptr_inc(input logic [ADDR_WIDTH-1:0] p);
        return (p == LAST_C) ? '0 : p + 1'b1;
    endfunction

    always_comb begin
        // Gating on the registered flags only keeps a same-cycle read from
        // opening space for a write (and vice versa).
        wr_ok  = !kill && !full_q;
        gnt0   = wr_ok && wr0_req && (!wr1_req || !rr_q);
        gnt1   = wr_ok && wr1_req && (!wr0_req ||  rr_q);
        wr_acc = gnt0 | gnt1;
        rd_acc = rd_req && !empty_q && !kill;

        rr_d     = rr_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;

        // Favour the other requester after any grant.
        if (gnt0) rr_d = 1'b1;
        if (gnt1) rr_d = 1'b0;
        if (wr_acc) wr_ptr_d = ptr_inc(wr_ptr_q);
        if (rd_acc) rd_ptr_d = ptr_inc(rd_ptr_q);

        unique case ({wr_acc, rd_acc})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (kill) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            rr_q       <= 1'b0;
            rd_valid_q <= 1'b0;
            full_q     <= 1'b0;
            empty_q    <= 1'b1;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            rr_q       <= rr_d;
            rd_valid_q <= rd_acc;
            full_q     <= (count_d == DEPTH_C);
            empty_q    <= (count_d == '0);
        end
    end

    assign wr0_ack     = gnt0;
    assign wr1_ack     = gnt1;
    assign rd_ack      = rd_acc;
    assign rd_valid    = rd_valid_q;
    assign ram_we      = wr_acc;
    assign ram_wr_addr = wr_ptr_q;
    assign ram_wr_data = gnt1 ? wr1_data : wr0_data;
    assign ram_rd_addr = rd_ptr_q;
    assign count       = count_q;
    assign full        = full_q;
    assign empty       = empty_q;

endmodule

// File: tb/tb_fifo_rr_ctrl.sv
module tb_fifo_rr_ctrl;
    localparam int DW    = 12;
    localparam int AW    = 12;
    localparam int DEPTH = 5;

    logic          clk = 1'b0;
    logic          kill;
    logic          wr0_req, wr1_req, rd_req;
    logic [DW-1:0] wr0_data, wr1_data;
    logic          wr0_ack, wr1_ack, rd_ack, rd_valid, ram_we, full, empty;
    logic [AW-1:0] ram_wr_addr, ram_rd_addr;
    logic [DW-1:0] ram_wr_data;
    logic [AW:0]   count;

    always #5 clk = ~clk;

    fifo_rr_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .STACK_DEPTH(DEPTH)) dut (
        .clk(clk), .kill(kill),
        .wr0_req(wr0_req), .wr0_data(wr0_data), .wr0_ack(wr0_ack),
        .wr1_req(wr1_req), .wr1_data(wr1_data), .wr1_ack(wr1_ack),
        .rd_req(rd_req), .rd_ack(rd_ack), .rd_valid(rd_valid),
        .ram_we(ram_we), .ram_wr_addr(ram_wr_addr), .ram_wr_data(ram_wr_data),
        .ram_rd_addr(ram_rd_addr), .count(count), .full(full), .empty(empty)
    );

    // Behavioural dual-port RAM with registered read.
    logic [DW-1:0] mem [0:(1<<AW)-1];
    logic [DW-1:0] rd_data;
    always @(posedge clk) begin
        if (ram_we) mem[ram_wr_addr] <= ram_wr_data;
        rd_data <= mem[ram_rd_addr];
    end

    int errors = 0;
    int checks = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Reference model: FIFO contents as a queue, pointers as plain modulo counters.
    logic [DW-1:0] fq[$];
    int wp = 0, rp = 0, rr = 0;
    bit pend0 = 0, pend1 = 0;
    logic [DW-1:0] d0 = '0, d1 = '0;

    typedef struct { logic [DW-1:0] d; int due; } rd_t;
    rd_t sb[$];
    int  cyc = 0;
    bit  mon_en = 0;

    // Monitor: checks rd_valid every cycle and pops the scoreboard on each pop.
    always @(posedge clk) begin
        #2;
        if (mon_en) begin
            bit ev;
            ev = (sb.size() > 0) && (sb[0].due == cyc);
            chk("rd_valid", {31'b0, rd_valid}, {31'b0, ev});
            if (ev) begin
                if (rd_valid) chk("rd_data", {20'b0, rd_data}, {20'b0, sb[0].d});
                void'(sb.pop_front());
            end
        end
    end

    task automatic step(input int p0, input int p1, input int pr, input int pk);
        bit g0, g1, ra, isfull, isempty;
        @(posedge clk); #1;
        cyc++;
        if (!pend0 && ($urandom % 100) < p0) begin pend0 = 1; d0 = DW'($urandom); end
        if (!pend1 && ($urandom % 100) < p1) begin pend1 = 1; d1 = DW'($urandom); end
        wr0_req = pend0; wr0_data = d0;
        wr1_req = pend1; wr1_data = d1;
        rd_req  = ($urandom % 100) < pr;
        kill    = ($urandom % 100) < pk;
        @(negedge clk);
        isfull  = (fq.size() == DEPTH);
        isempty = (fq.size() == 0);
        g0 = 0; g1 = 0;
        if (!kill && !isfull) begin
            if (pend0 && pend1) begin g0 = (rr == 0); g1 = (rr == 1); end
            else begin g0 = pend0; g1 = pend1; end
        end
        ra = rd_req && !isempty && !kill;
        chk("wr0_ack", {31'b0, wr0_ack}, {31'b0, g0});
        chk("wr1_ack", {31'b0, wr1_ack}, {31'b0, g1});
        chk("rd_ack",  {31'b0, rd_ack},  {31'b0, ra});
        chk("ram_we",  {31'b0, ram_we},  {31'b0, g0 | g1});
        chk("ram_wr_addr", {20'b0, ram_wr_addr}, wp);
        chk("ram_wr_data", {20'b0, ram_wr_data}, {20'b0, g1 ? d1 : d0});
        chk("ram_rd_addr", {20'b0, ram_rd_addr}, rp);
        chk("count", {19'b0, count}, fq.size());
        chk("full",  {31'b0, full},  {31'b0, isfull});
        chk("empty", {31'b0, empty}, {31'b0, isempty});
        // Advance the model to the post-edge state.
        if (ra) begin
            sb.push_back('{d: fq[0], due: cyc + 1});
            void'(fq.pop_front());
            rp = (rp + 1) % DEPTH;
        end
        if (g0) begin fq.push_back(d0); pend0 = 0; rr = 1; end
        if (g1) begin fq.push_back(d1); pend1 = 0; rr = 0; end
        if (g0 || g1) wp = (wp + 1) % DEPTH;
        if (kill) begin fq.delete(); wp = 0; rp = 0; rr = 0; end
    endtask

    initial begin
        kill = 1; wr0_req = 0; wr1_req = 0; rd_req = 0; wr0_data = '0; wr1_data = '0;
        repeat (2) @(posedge clk);
        #1 kill = 0;
        @(negedge clk);
        mon_en = 1;
        // Idle after reset.
        repeat (3) step(0, 0, 0, 0);
        // Fill from requester 0 beyond capacity, then drain.
        repeat (9) step(100, 0, 0, 0);
        repeat (8) step(0, 0, 100, 0);
        // Both requesters held high: round-robin, then drain.
        repeat (9) step(100, 100, 0, 0);
        repeat (8) step(0, 0, 100, 0);
        // Boundary: full with read+write, empty with read+write.
        repeat (8) step(100, 0, 0, 0);
        repeat (2) step(100, 0, 100, 0);
        repeat (8) step(0, 0, 100, 0);
        repeat (2) step(0, 100, 100, 0);
        // Interleaved traffic exercising pointer wrap.
        repeat (80) step(50, 30, 60, 0);
        // Random traffic with occasional kill.
        repeat (400) step(60, 60, 55, 3);
        // Quiesce so every accepted read is observed.
        repeat (4) step(0, 0, 0, 0);
        chk("scoreboard_drained", sb.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
